mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter for the 1 KB byte-addressed `ram256x32` memory. It shares the single RAM port between the instruction-fetch requester (F) and the load/store requester (D). It drives the RAM's MOV/ReadWrite/type/Address/DataIn/IR inputs and waits for MOC. It returns read data with a one-cycle acknowledge and flags a bus error if MOC never arrives.

## Interface
Parameters:
- `TIMEOUT`, 15: cycles to wait for MOC before aborting the access; legal range 1..255.

Ports:
- `Clk`, in, 1: clock; all state updates on the rising edge.
- `Clr_n`, in, 1: reset, asynchronous, active-low.
- `F_Req`, in, 1: fetch request; held high with `F_Addr` stable until `F_Ack`.
- `F_Addr`, in, 32: fetch byte address.
- `F_Ack`, out, 1: one-cycle pulse; `RData` is valid in the same cycle.
- `D_Req`, in, 1: data request; held high with its payload stable until `D_Ack`.
- `D_Write`, in, 1: 1 = store, 0 = load.
- `D_Addr`, in, 32: data byte address.
- `D_WData`, in, 32: store data.
- `D_IR`, in, 32: instruction word, passed to the RAM for size/sign decoding.
- `D_Ack`, out, 1: one-cycle pulse.
- `Err`, out, 1: pulses together with `F_Ack` or `D_Ack` when that access timed out.
- `RData`, out, 32: read data, registered; holds its value between acks.
- `MOV`, out, 1: RAM access strobe.
- `ReadWrite`, out, 1: to RAM; 1 = read.
- `Type`, out, 1: to RAM; 1 = instruction fetch (word, big-endian), 0 = IR-decoded data access.
- `Address`, out, 32: to RAM.
- `DataIn`, out, 32: to RAM.
- `IR`, out, 32: to RAM.
- `MOC`, in, 1: RAM completion.
- `DataOut`, in, 32: RAM read data.

## Operation
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - `MOV`=0.
  - If any Req is high, arbitrate and register the winner's payload onto the RAM outputs, then go to ACCESS.
  - Arbitration is round-robin on a `last` flag. On a simultaneous `F_Req`/`D_Req`, the requester that was not granted last wins. With a single request, that request wins.
  - `last` resets to D, so the first tie goes to F.
- Payload per winner:
  - F: `Type`=1, `ReadWrite`=1, `Address`=`F_Addr`, `IR`=0, `DataIn`=0.
  - D: `Type`=0, `ReadWrite`=~`D_Write`, `Address`=`D_Addr`, `DataIn`=`D_WData`, `IR`=`D_IR`.
- ACCESS:
  - `MOV`=1. The timeout counter starts at 0 and increments each cycle.
  - If `MOC`=1 is sampled, capture `DataOut` into `RData` (reads only; stores leave `RData` unchanged) and go to COMPLETE.
  - If the counter reaches `TIMEOUT` without `MOC`, set the error flag, load `RData`=0, and go to COMPLETE.
- COMPLETE:
  - `MOV`=0.
  - Pulse the granted requester's Ack. Pulse `Err` in the same cycle if the error flag is set.
  - Update `last` to the requester just served, then go to IDLE.
- The RAM only re-evaluates on a MOV/ReadWrite/type change. The COMPLETE→IDLE path therefore guarantees at least 2 cycles of `MOV`=0 between any two accesses; this gap is mandatory.
- A Req that is still high in the cycle after its Ack is treated as a new request.
- Reset mid-access: all state clears immediately and `MOV` drops asynchronously. No Ack is issued for the aborted access.
- Addresses pass through unchecked; the RAM handles wrap within 1024 bytes.

## Timing
- Reset values:
  - State=IDLE, `last`=D, counter=0.
  - `MOV`=0, `ReadWrite`=1, `Type`=0.
  - `Address`, `DataIn`, `IR`, `RData` = 0.
  - `F_Ack`, `D_Ack`, `Err` = 0.
- Latency: Req is first sampled high at edge k. `MOV` goes high after edge k. `MOC` is sampled at edge k+1 at the earliest. Ack is high during the cycle after edge k+2. Minimum latency is 3 cycles to Ack.
- Throughput: at most one access per 4 cycles (IDLE, ACCESS, COMPLETE, IDLE).
- Timeout path: Ack+`Err` arrive `TIMEOUT`+2 cycles after the grant edge.
- All RAM-side outputs are registered and stay stable throughout ACCESS.

## Structure
- Shared package `mem_pkg`:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, COMPLETE=2'd2);
  - requester IDs (REQ_F=1'b0, REQ_D=1'b1);
  - `TYPE_FETCH`=1'b1, `TYPE_DATA`=1'b0.
- One natural sub-module: `rr_arbiter2`, a 2-way round-robin chooser with a `last` register and an update strobe. The FSM and the timeout counter live in the top module.

## Test plan
- Single fetch: `F_Addr`=0x10, RAM model answers `MOC` in 1 cycle with 0xE3A01005 → `MOV`=1, `Type`=1 for exactly 1 cycle; `F_Ack` arrives 3 cycles after Req with `RData`=0xE3A01005; `D_Ack`=0, `Err`=0.
- Simultaneous `F_Req` and `D_Req` (load 0x20) after reset → F is served first, then D. The second grant's `MOV` rises after at least 2 cycles of `MOV`=0. The next tie goes to D.
- Store: `D_Write`=1, `D_Addr`=0x40, `D_WData`=0xCAFEBABE, `D_IR`=0xE5801000 → RAM sees `ReadWrite`=0, `Type`=0 with matching `IR`/`DataIn`; `D_Ack` pulses; `RData` is unchanged.
- Timeout: `MOC` held at 0, `TIMEOUT`=15 → `D_Ack` and `Err` pulse together 17 cycles after the grant edge; `RData`=0; `MOV` is back to 0.
- Reset mid-ACCESS: assert `Clr_n`=0 while `MOV`=1 → `MOV` and all outputs drop to reset values with no clock edge needed; no Ack follows release.
- Held Req: `F_Req` kept high for 3 consecutive accesses with `D_Req`=0 → 3 `F_Ack` pulses spaced 4 cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  // Requester identifiers
  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

  // RAM access type
  localparam logic TYPE_FETCH = 1'b1;
  localparam logic TYPE_DATA  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin chooser. On a tie, the requester not
//               served last wins. 'last' is updated by a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import mem_pkg::*;
(
  input  logic Clk,
  input  logic Clr_n,
  input  logic req_f_i,
  input  logic req_d_i,
  input  logic update_i,
  input  logic served_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  logic last_q;

  // Remember who was served most recently; resets to D so the first tie goes to F
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      last_q <= REQ_D;
    end else if (update_i) begin
      last_q <= served_i;
    end
  end

  // Pick the winner: sole requester, or the one not served last on a tie
  always_comb begin
    gnt_valid_o = req_f_i | req_d_i;
    gnt_id_o    = REQ_F;
    if (req_f_i && req_d_i) begin
      gnt_id_o = ~last_q;
    end else if (req_d_i) begin
      gnt_id_o = REQ_D;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single ram256x32 port between the fetch (F) and
//               load/store (D) requesters. Drives the registered RAM-side
//               strobes, waits for MOC with a timeout, and returns a
//               one-cycle Ack (plus Err on timeout) with registered RData.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic        F_Req,
  input  logic [31:0] F_Addr,
  output logic        F_Ack,
  input  logic        D_Req,
  input  logic        D_Write,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_WData,
  input  logic [31:0] D_IR,
  output logic        D_Ack,
  output logic        Err,
  output logic [31:0] RData,
  output logic        MOV,
  output logic        ReadWrite,
  output logic        Type,
  output logic [31:0] Address,
  output logic [31:0] DataIn,
  output logic [31:0] IR,
  input  logic        MOC,
  input  logic [31:0] DataOut
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        tofl_q, tofl_d;
  logic        mov_q, mov_d;
  logic        rw_q, rw_d;
  logic        type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fack_q, fack_d;
  logic        dack_q, dack_d;
  logic        err_q, err_d;

  logic        arb_valid;
  logic        arb_id;
  logic        arb_update;

  rr_arbiter2 u_arb (
    .Clk         (Clk),
    .Clr_n       (Clr_n),
    .req_f_i     (F_Req),
    .req_d_i     (D_Req),
    .update_i    (arb_update),
    .served_i    (gnt_q),
    .gnt_valid_o (arb_valid),
    .gnt_id_o    (arb_id)
  );

  // State and all registered outputs; reset drops MOV without a clock edge
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      gnt_q   <= REQ_F;
      tofl_q  <= 1'b0;
      mov_q   <= 1'b0;
      rw_q    <= 1'b1;
      type_q  <= TYPE_DATA;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ir_q    <= 32'd0;
      rdata_q <= 32'd0;
      fack_q  <= 1'b0;
      dack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      tofl_q  <= tofl_d;
      mov_q   <= mov_d;
      rw_q    <= rw_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      rdata_q <= rdata_d;
      fack_q  <= fack_d;
      dack_q  <= dack_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode for the IDLE/ACCESS/COMPLETE sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    tofl_d     = tofl_q;
    mov_d      = mov_q;
    rw_d       = rw_q;
    type_d     = type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ir_d       = ir_q;
    rdata_d    = rdata_q;
    fack_d     = 1'b0;
    dack_d     = 1'b0;
    err_d      = 1'b0;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        mov_d = 1'b0;
        // During the Ack cycle the served requester still holds Req; it only
        // counts as a new request one cycle later, which also enforces the
        // mandatory MOV-low gap before the next access.
        if (arb_valid && !(fack_q || dack_q)) begin
          gnt_d   = arb_id;
          cnt_d   = 8'd0;
          tofl_d  = 1'b0;
          mov_d   = 1'b1;
          state_d = ACCESS;
          if (arb_id == REQ_F) begin
            type_d  = TYPE_FETCH;
            rw_d    = 1'b1;
            addr_d  = F_Addr;
            ir_d    = 32'd0;
            wdata_d = 32'd0;
          end else begin
            type_d  = TYPE_DATA;
            rw_d    = ~D_Write;
            addr_d  = D_Addr;
            ir_d    = D_IR;
            wdata_d = D_WData;
          end
        end
      end

      ACCESS: begin
        if (MOC) begin
          if (rw_q) begin
            rdata_d = DataOut;
          end
          mov_d   = 1'b0;
          state_d = COMPLETE;
        end else if (cnt_q == TO_LIMIT) begin
          tofl_d  = 1'b1;
          rdata_d = 32'd0;
          mov_d   = 1'b0;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      COMPLETE: begin
        mov_d      = 1'b0;
        fack_d     = (gnt_q == REQ_F);
        dack_d     = (gnt_q == REQ_D);
        err_d      = tofl_q;
        arb_update = 1'b1;
        cnt_d      = 8'd0;
        state_d    = IDLE;
      end

      default: begin
        mov_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign MOV       = mov_q;
  assign ReadWrite = rw_q;
  assign Type      = type_q;
  assign Address   = addr_q;
  assign DataIn    = wdata_q;
  assign IR        = ir_q;
  assign RData     = rdata_q;
  assign F_Ack     = fack_q;
  assign D_Ack     = dack_q;
  assign Err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter with a simple RAM
//               responder that answers MOC one cycle after MOV rises.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        Clk;
  logic        Clr_n;
  logic        F_Req;
  logic [31:0] F_Addr;
  logic        F_Ack;
  logic        D_Req;
  logic        D_Write;
  logic [31:0] D_Addr;
  logic [31:0] D_WData;
  logic [31:0] D_IR;
  logic        D_Ack;
  logic        Err;
  logic [31:0] RData;
  logic        MOV;
  logic        ReadWrite;
  logic        Type;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] IR;
  logic        MOC;
  logic [31:0] DataOut;

  int          n_cmp;
  int          n_err;
  logic        answer_en;
  logic [31:0] ram_data;
  int          zero_run;
  int          last_gap;
  logic        mov_prev;

  mem_port_arbiter #(.TIMEOUT(15)) dut (
    .Clk       (Clk),
    .Clr_n     (Clr_n),
    .F_Req     (F_Req),
    .F_Addr    (F_Addr),
    .F_Ack     (F_Ack),
    .D_Req     (D_Req),
    .D_Write   (D_Write),
    .D_Addr    (D_Addr),
    .D_WData   (D_WData),
    .D_IR      (D_IR),
    .D_Ack     (D_Ack),
    .Err       (Err),
    .RData     (RData),
    .MOV       (MOV),
    .ReadWrite (ReadWrite),
    .Type      (Type),
    .Address   (Address),
    .DataIn    (DataIn),
    .IR        (IR),
    .MOC       (MOC),
    .DataOut   (DataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM responder: answers one cycle after MOV rises; also measures MOV-low gaps
  initial begin
    MOC      = 1'b0;
    DataOut  = 32'd0;
    zero_run = 100;
    last_gap = 0;
    mov_prev = 1'b0;
    forever begin
      @(negedge Clk);
      MOC     = MOV && answer_en;
      DataOut = (MOV && answer_en) ? ram_data : 32'd0;
      if (MOV && !mov_prev) last_gap = zero_run;
      zero_run = MOV ? 0 : zero_run + 1;
      mov_prev = MOV;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  int   ack_cnt;
  int   ack_pos [3];
  logic any_ack;

  initial begin
    n_cmp = 0; n_err = 0;
    Clr_n = 1'b0;
    F_Req = 1'b0; F_Addr = 32'd0;
    D_Req = 1'b0; D_Write = 1'b0; D_Addr = 32'd0; D_WData = 32'd0; D_IR = 32'd0;
    answer_en = 1'b1; ram_data = 32'd0;

    // ---------------- reset values ----------------
    step(2);
    chk("rst_mov",   MOV, 0);
    chk("rst_rw",    ReadWrite, 1);
    chk("rst_type",  Type, 0);
    chk("rst_addr",  Address, 0);
    chk("rst_rdata", RData, 0);
    chk("rst_acks",  {Err, D_Ack, F_Ack}, 0);
    @(negedge Clk); Clr_n = 1'b1;

    // ---------------- single fetch ----------------
    @(negedge Clk);
    F_Addr = 32'h10; F_Req = 1'b1; ram_data = 32'hE3A01005;
    step(1);                          // grant edge k
    chk("f1_mov",  MOV, 1);
    chk("f1_type", Type, 1);
    chk("f1_rw",   ReadWrite, 1);
    chk("f1_addr", Address, 32'h10);
    step(1);                          // k+1: MOC sampled
    chk("f1_mov_one_cycle", MOV, 0);
    chk("f1_ack_early", F_Ack, 0);
    step(1);                          // k+2: Ack cycle
    chk("f1_fack", F_Ack, 1);
    chk("f1_dack", D_Ack, 0);
    chk("f1_err",  Err, 0);
    chk("f1_rdata", RData, 32'hE3A01005);
    @(negedge Clk); F_Req = 1'b0;
    step(1);
    chk("f1_ack_pulse", F_Ack, 0);

    // ---------------- tie after reset ----------------
    @(negedge Clk); Clr_n = 1'b0;
    #1 chk("rst2_rdata", RData, 0);
    @(negedge Clk); Clr_n = 1'b1;
    @(negedge Clk);
    F_Addr = 32'h100; F_Req = 1'b1;
    D_Addr = 32'h20; D_Write = 1'b0; D_IR = 32'hE5901000; D_WData = 32'h0; D_Req = 1'b1;
    ram_data = 32'h11111111;
    step(1);                          // k: F wins first tie
    chk("tie1_type", Type, 1);
    chk("tie1_addr", Address, 32'h100);
    step(2);                          // k+2
    chk("tie1_fack", F_Ack, 1);
    chk("tie1_dack", D_Ack, 0);
    chk("tie1_rdata", RData, 32'h11111111);
    @(negedge Clk); ram_data = 32'h22222222;   // both requests still held
    step(1);                          // k+3: no grant during Ack cycle
    chk("tie_gap_mov", MOV, 0);
    step(1);                          // k+4: second tie goes to D
    chk("tie2_mov",  MOV, 1);
    chk("tie2_type", Type, 0);
    chk("tie2_rw",   ReadWrite, 1);
    chk("tie2_addr", Address, 32'h20);
    chk("tie2_ir",   IR, 32'hE5901000);
    step(1);
    chk("tie2_gap_ge2", (last_gap >= 2) ? 1 : 0, 1);
    step(1);                          // k+6
    chk("tie2_dack", D_Ack, 1);
    chk("tie2_fack", F_Ack, 0);
    chk("tie2_rdata", RData, 32'h22222222);
    @(negedge Clk); D_Req = 1'b0; ram_data = 32'h33333333;
    step(2);                          // k+8: F served again
    chk("tie3_type", Type, 1);
    chk("tie3_addr", Address, 32'h100);
    step(2);
    chk("tie3_fack", F_Ack, 1);
    chk("tie3_rdata", RData, 32'h33333333);
    @(negedge Clk); F_Req = 1'b0;
    step(2);

    // ---------------- store ----------------
    @(negedge Clk);
    D_Write = 1'b1; D_Addr = 32'h40; D_WData = 32'hCAFEBABE; D_IR = 32'hE5801000;
    D_Req = 1'b1; ram_data = 32'hDEADBEEF;
    step(1);
    chk("st_mov",  MOV, 1);
    chk("st_rw",   ReadWrite, 0);
    chk("st_type", Type, 0);
    chk("st_addr", Address, 32'h40);
    chk("st_din",  DataIn, 32'hCAFEBABE);
    chk("st_ir",   IR, 32'hE5801000);
    step(2);
    chk("st_dack", D_Ack, 1);
    chk("st_err",  Err, 0);
    chk("st_rdata_kept", RData, 32'h33333333);
    @(negedge Clk); D_Req = 1'b0;
    step(2);

    // ---------------- timeout ----------------
    @(negedge Clk);
    answer_en = 1'b0;
    D_Write = 1'b0; D_Addr = 32'h80; D_IR = 32'hE5901000; D_Req = 1'b1;
    step(1);                          // grant edge k
    chk("to_mov_start", MOV, 1);
    step(15);                         // k+15: still waiting
    chk("to_mov_hold", MOV, 1);
    chk("to_dack_early", D_Ack, 0);
    step(1);                          // k+16: aborted into COMPLETE
    chk("to_mov_drop", MOV, 0);
    chk("to_dack_notyet", D_Ack, 0);
    step(1);                          // k+17 = TIMEOUT+2
    chk("to_dack", D_Ack, 1);
    chk("to_err",  Err, 1);
    chk("to_rdata", RData, 0);
    chk("to_mov",  MOV, 0);
    @(negedge Clk); D_Req = 1'b0; answer_en = 1'b1;
    step(1);
    chk("to_err_pulse", Err, 0);
    step(2);

    // ---------------- held fetch request ----------------
    @(negedge Clk);
    F_Addr = 32'h200; F_Req = 1'b1; ram_data = 32'h44444444;
    ack_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      step(1);
      if (F_Ack) begin
        if (ack_cnt < 3) ack_pos[ack_cnt] = c;
        ack_cnt++;
      end
    end
    chk("held_count", ack_cnt, 3);
    chk("held_pos0", ack_pos[0], 2);
    chk("held_pos1", ack_pos[1], 6);
    chk("held_pos2", ack_pos[2], 10);
    @(negedge Clk); F_Req = 1'b0;
    step(4);

    // ---------------- reset mid-access ----------------
    @(negedge Clk);
    answer_en = 1'b0; F_Addr = 32'h300; F_Req = 1'b1;
    step(1);
    chk("mr_mov_before", MOV, 1);
    #2 Clr_n = 1'b0;
    #1;
    chk("mr_mov",   MOV, 0);
    chk("mr_rw",    ReadWrite, 1);
    chk("mr_type",  Type, 0);
    chk("mr_addr",  Address, 0);
    chk("mr_rdata", RData, 0);
    @(negedge Clk); F_Req = 1'b0;
    @(negedge Clk); Clr_n = 1'b1; answer_en = 1'b1;
    any_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(1);
      any_ack = any_ack | F_Ack | D_Ack | Err;
    end
    chk("mr_no_ack", any_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
